// File: rtl/m_ifetch_buf_pkg.sv
// Shared definitions for the instruction prefetch buffer.
//   NOP_INSTR  : word presented on instr while the queue is empty
//   DEPTH_MIN/DEPTH_MAX : supported queue depth range (power of two)
//   ENTRY_W    : queue entry width, {instr[31:0], pc[31:2]}
//   fetch_state_t : fetch FSM encoding
//   word_to_pc : word address -> byte PC
package m_ifetch_buf_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned DEPTH_MIN = 2;
  localparam int unsigned DEPTH_MAX = 8;
  localparam int unsigned ENTRY_W   = 62;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_to_pc(input logic [29:0] adr);
    return {adr, 2'b00};
  endfunction

endpackage

// File: rtl/m_ifetch_buf_if.sv
// Prefetch buffer bus bundle.
//   Wishbone-classic read port: i_adr_o, i_stb_o (buffer -> slave), i_ack_i, i_dat_i (slave -> buffer)
//   Instruction port: instr, instr_pc, instr_valid (buffer -> consumer), instr_take (consumer -> buffer)
// master: the prefetch buffer's view; slave: the bus slave / instruction consumer view.
interface m_ifetch_buf_if;

  logic [29:0] i_adr_o;
  logic        i_stb_o;
  logic        i_ack_i;
  logic [31:0] i_dat_i;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_take;

  modport master (
    output i_adr_o, i_stb_o, instr, instr_pc, instr_valid,
    input  i_ack_i, i_dat_i, instr_take
  );

  modport slave (
    input  i_adr_o, i_stb_o, instr, instr_pc, instr_valid,
    output i_ack_i, i_dat_i, instr_take
  );

endinterface

// File: rtl/m_ifetch_fifo.sv
// Synchronous FIFO holding fetched words with their word addresses.
//   clk, rstn : clock, asynchronous active-low reset
//   flush     : empty the queue (wins over push/pop)
//   push      : write wr_data at the tail
//   pop       : advance the head
//   wr_data   : {instr, pc[31:2]}
//   rd_data   : head entry straight from storage (stale when count==0)
//   count     : current occupancy, 0..DEPTH
// The caller guarantees no push when full unless popping in the same cycle.
module m_ifetch_fifo
  import m_ifetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ENTRY_W-1:0]         wr_data,
  output logic [ENTRY_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  // Storage has no reset; the top masks the head while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/m_ifetch_buf.sv
// Instruction prefetch buffer.
// Fetches 32-bit words over a Wishbone-classic read port, queues them with their PCs and
// presents the queue head with a valid/take handshake. A redirect flushes the queue and
// restarts fetch at a new PC; an access already on the bus is completed and its data dropped.
//   clk, rstn    : clock, asynchronous active-low reset
//   corerunning  : 0 stops new fetches; an access in flight still completes and is queued
//   redirect     : one-cycle flush/restart pulse, redirect_pc gives the new byte PC
//   bus          : read port and instruction port (see m_ifetch_buf_if)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no access on the bus
// ST_REQ  | i_stb_o high, i_adr_o held until i_ack_i
module m_ifetch_buf
  import m_ifetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           corerunning,
  input  logic           redirect,
  input  logic [31:0]    redirect_pc,
  m_ifetch_buf_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t       state_q, state_d;
  logic [29:0]        adr_q, adr_d;
  logic [29:0]        redir_q, redir_d;
  logic               discard_q, discard_d;
  logic [CW-1:0]      count;
  logic [CW-1:0]      cnt_after;
  logic [ENTRY_W-1:0] head;
  logic               stb, ack_acc, empty, push, pop, room;
  logic               unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign stb     = (state_q == ST_REQ);
  assign ack_acc = stb & bus.i_ack_i;
  assign empty   = (count == '0);
  assign pop     = bus.instr_take & ~empty & ~redirect;
  assign push    = ack_acc & ~discard_q & ~redirect;

  // Occupancy after this cycle's push/pop/flush; a new request needs a slot beyond it.
  assign cnt_after = redirect ? '0 : (count - CW'(pop) + CW'(push));
  assign room      = (cnt_after < CW'(DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (corerunning && room) state_d = ST_REQ;
      ST_REQ:  if (ack_acc) state_d = (corerunning && room) ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address, pending-redirect target and discard flag.
  // A redirect during an unacked access parks the target in redir_q; the access keeps
  // its address and its ack only swaps the target in.
  always_comb begin
    adr_d     = adr_q;
    redir_d   = redir_q;
    discard_d = discard_q;
    if (ack_acc) begin
      adr_d     = discard_q ? redir_q : (adr_q + 30'd1);
      discard_d = 1'b0;
    end
    if (redirect) begin
      if (stb && !bus.i_ack_i) begin
        discard_d = 1'b1;
        redir_d   = redirect_pc[31:2];
      end else begin
        adr_d = redirect_pc[31:2];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adr_q     <= RESET_PC[31:2];
      redir_q   <= RESET_PC[31:2];
      discard_q <= 1'b0;
    end else begin
      adr_q     <= adr_d;
      redir_q   <= redir_d;
      discard_q <= discard_d;
    end
  end

  m_ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (redirect),
    .push    (push),
    .pop     (pop),
    .wr_data ({bus.i_dat_i, adr_q}),
    .rd_data (head),
    .count   (count)
  );

  assign bus.i_stb_o     = stb;
  assign bus.i_adr_o     = adr_q;
  assign bus.instr_valid = ~empty;
  assign bus.instr       = empty ? NOP_INSTR : head[61:30];
  // While empty, instr_pc shows the next fetch PC (RESET_PC after reset).
  assign bus.instr_pc    = empty ? word_to_pc(adr_q) : word_to_pc(head[29:0]);

endmodule

// File: tb/tb_m_ifetch_buf.sv
module tb_m_ifetch_buf;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        corerunning;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [7:0]  wait_cfg;
  logic [7:0]  wcnt;
  bit          sb_en;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  m_ifetch_buf_if ifc();

  m_ifetch_buf #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .corerunning (corerunning),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (ifc)
  );

  always #5 clk = ~clk;

  // Slave: acks after wait_cfg wait states, returns the word address as data.
  assign ifc.i_ack_i = ifc.i_stb_o && (wcnt >= wait_cfg);
  assign ifc.i_dat_i = {2'b00, ifc.i_adr_o};

  always @(posedge clk or negedge rstn) begin
    if (!rstn)                              wcnt <= 8'd0;
    else if (!ifc.i_stb_o || ifc.i_ack_i)   wcnt <= 8'd0;
    else                                    wcnt <= wcnt + 8'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every accepted take pops the oldest expected PC.
  always @(negedge clk) begin
    if (sb_en && rstn && ifc.instr_valid && ifc.instr_take && !redirect) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(ifc.instr_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [31:0] pc;
        pc = exp_q.pop_front();
        chk("sb_pc", 64'(ifc.instr_pc), 64'(pc));
        chk("sb_instr", 64'(ifc.instr), 64'({2'b00, pc[31:2]}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends at the first cycle after reset release (window 0).
  task automatic start_test(input logic [7:0] wc, input bit run, input bit take, input bit sb);
    tick();
    rstn = 1'b0;
    sb_en = 1'b0;
    exp_q.delete();
    wait_cfg = wc;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    corerunning = run;
    ifc.instr_take = take;
    tick();
    rstn = 1'b1;
    sb_en = sb;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick();
    chk(name, 64'(exp_q.size()), 64'd0);
    ifc.instr_take = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    bit          run;
    bit          take;
    bit          e_stb;
    logic [29:0] e_adr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    corerunning = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    wait_cfg = 8'd0;
    sb_en = 1'b0;
    ifc.instr_take = 1'b0;

    // Streaming with take every cycle, then DEPTH back-pressure with take held low.
    //          rst run take stb adr    valid pc
    vecs[0]  = '{1, 1, 1, 0, 30'd0, 0, 32'h0};
    vecs[1]  = '{0, 1, 1, 1, 30'd0, 0, 32'h0};
    vecs[2]  = '{0, 1, 1, 1, 30'd1, 1, 32'h0};
    vecs[3]  = '{0, 1, 1, 1, 30'd2, 1, 32'h4};
    vecs[4]  = '{0, 1, 1, 1, 30'd3, 1, 32'h8};
    vecs[5]  = '{0, 1, 1, 1, 30'd4, 1, 32'hC};
    vecs[6]  = '{1, 1, 0, 0, 30'd0, 0, 32'h0};
    vecs[7]  = '{0, 1, 0, 1, 30'd0, 0, 32'h0};
    vecs[8]  = '{0, 1, 0, 1, 30'd1, 1, 32'h0};
    vecs[9]  = '{0, 1, 0, 0, 30'd2, 1, 32'h0};
    vecs[10] = '{0, 1, 1, 0, 30'd2, 1, 32'h0};
    vecs[11] = '{0, 1, 0, 1, 30'd2, 1, 32'h4};
    vecs[12] = '{0, 1, 0, 0, 30'd3, 1, 32'h4};

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) start_test(8'd0, vecs[i].run, vecs[i].take, 1'b0);
      else tick();
      corerunning = vecs[i].run;
      ifc.instr_take = vecs[i].take;
      @(negedge clk);
      chk($sformatf("vec%0d_stb", i), 64'(ifc.i_stb_o), 64'(vecs[i].e_stb));
      chk($sformatf("vec%0d_adr", i), 64'(ifc.i_adr_o), 64'(vecs[i].e_adr));
      chk($sformatf("vec%0d_valid", i), 64'(ifc.instr_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_pc", i), 64'(ifc.instr_pc), 64'(vecs[i].e_pc));
      chk($sformatf("vec%0d_instr", i), 64'(ifc.instr),
          vecs[i].e_valid ? 64'({2'b00, vecs[i].e_pc[31:2]}) : 64'(NOP));
    end

    // Redirect during a 3-wait-state access: stale word dropped, refetch at 0x100.
    start_test(8'd3, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t3_stb_held", 64'(ifc.i_stb_o), 64'd1);
    chk("t3_adr_held", 64'(ifc.i_adr_o), 64'd0);
    chk("t3_valid", 64'(ifc.instr_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("t3_adr_at_ack", 64'(ifc.i_adr_o), 64'd0);
    tick();
    @(negedge clk);
    chk("t3_new_stb", 64'(ifc.i_stb_o), 64'd1);
    chk("t3_new_adr", 64'(ifc.i_adr_o), 64'h40);
    chk("t3_stale_dropped", 64'(ifc.instr_valid), 64'd0);
    drain("t3_drain");

    // Two redirects during one stalled access: the later target wins.
    start_test(8'd3, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h208);
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect_pc = 32'h0000_0207;
    tick();
    redirect = 1'b0;
    tick();
    @(negedge clk);
    chk("t3b_adr", 64'(ifc.i_adr_o), 64'h81);
    drain("t3b_drain");

    // Redirect coinciding with ack and take.
    start_test(8'd0, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    tick();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_valid", 64'(ifc.instr_valid), 64'd0);
    chk("t4_instr_nop", 64'(ifc.instr), 64'(NOP));
    chk("t4_stb", 64'(ifc.i_stb_o), 64'd1);
    chk("t4_adr", 64'(ifc.i_adr_o), 64'h80);
    drain("t4_drain");

    // corerunning drops mid-access: word still queued, no further requests.
    start_test(8'd2, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    tick();
    corerunning = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("t5_valid", 64'(ifc.instr_valid), 64'd1);
    chk("t5_pc", 64'(ifc.instr_pc), 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_stb", 64'(ifc.i_stb_o), 64'd0);
      tick();
    end
    corerunning = 1'b1;
    ifc.instr_take = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_resume_stb", 64'(ifc.i_stb_o), 64'd1);
    chk("t5_resume_adr", 64'(ifc.i_adr_o), 64'd1);
    drain("t5_drain");

    // Wrap of the word address after a redirect taken together with an ack.
    start_test(8'd0, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t7_adr", 64'(ifc.i_adr_o), 64'h3FFF_FFFF);
    chk("t7_valid", 64'(ifc.instr_valid), 64'd0);
    drain("t7_drain");

    // Asynchronous reset in the middle of a stalled access.
    start_test(8'd3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    chk("t6_pre_stb", 64'(ifc.i_stb_o), 64'd1);
    chk("t6_pre_adr", 64'(ifc.i_adr_o), 64'd1);
    chk("t6_pre_valid", 64'(ifc.instr_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_stb", 64'(ifc.i_stb_o), 64'd0);
    chk("t6_async_valid", 64'(ifc.instr_valid), 64'd0);
    chk("t6_async_instr", 64'(ifc.instr), 64'(NOP));
    chk("t6_async_pc", 64'(ifc.instr_pc), 64'h0);
    chk("t6_async_adr", 64'(ifc.i_adr_o), 64'd0);
    exp_q.delete();
    exp_q.push_back(32'h0);
    tick();
    rstn = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_refetch_stb", 64'(ifc.i_stb_o), 64'd1);
    chk("t6_refetch_adr", 64'(ifc.i_adr_o), 64'd0);
    ifc.instr_take = 1'b1;
    drain("t6_drain");

    sb_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
